// File: rtl/data_memory_sync.sv
// MEM-stage data RAM: byte/halfword/word loads and stores, registered reads, range/alignment errors.
// Optional post-reset clear sequencer enabled by defining DMEM_CLEAR_EN.
module data_memory_sync #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h10001000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_signed,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        addr_err,
    output logic        busy
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

`ifdef DMEM_CLEAR_EN
    logic [31:0] mem [DEPTH];
`else
    logic [31:0] mem [DEPTH] = '{default: '0};
`endif

    logic [31:0]      offset;
    logic [IDX_W-1:0] index;
    logic             in_range;
    logic             aligned;
    logic             ok;
    logic             accept;
    logic [31:0]      word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic [31:0]      lane_data;
    logic [31:0]      lane_mask;
    logic [31:0]      merged;

    assign offset   = address - BASE_ADDR;
    assign index    = offset[IDX_W+1:2];
    assign in_range = (address >= BASE_ADDR) && (offset < SPAN);
    assign ok       = in_range && aligned;
    assign accept   = (mem_read || mem_write) && !busy;
    assign word     = mem[index];

    always_comb begin
        aligned = 1'b0;
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !address[0];
            2'b10:   aligned = (address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Load path reads the pre-store word, which gives read-before-write for free.
    always_comb begin
        byte_sel = word[7:0];
        case (address[1:0])
            2'b00: byte_sel = word[7:0];
            2'b01: byte_sel = word[15:8];
            2'b10: byte_sel = word[23:16];
            2'b11: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = address[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_val = load_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            2'b01:   load_val = load_signed ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        case (size)
            2'b00: begin
                lane_data = {4{write_data[7:0]}};
                lane_mask = 32'h000000FF << {address[1:0], 3'b000};
            end
            2'b01: begin
                lane_data = {2{write_data[15:0]}};
                lane_mask = 32'h0000FFFF << {address[1], 4'b0000};
            end
            default: begin
                lane_data = write_data;
                lane_mask = '1;
            end
        endcase
        merged = (word & ~lane_mask) | (lane_data & lane_mask);
    end

`ifdef DMEM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;
    state_t           state, next_state;
    logic [IDX_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == IDX_W'(DEPTH - 1))
                    next_state = READY;
            end
            READY: next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (busy)
            mem[cnt] <= '0;
        else if (accept && ok && mem_write)
            mem[index] <= merged;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (accept && ok && mem_write)
            mem[index] <= merged;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            read_valid <= accept && mem_read;
            addr_err   <= accept && !ok;
            if (accept && mem_read)
                read_data <= ok ? load_val : '0;
        end
    end
endmodule
